unsigned_divide: RTL
====================

UNSIGNED_DIVIDE -- requirements
Module: unsigned_divide

Interface
REQ-001 SHALL have parameter NWIDTH, default 16: dividend and quotient width in bits.
REQ-002 SHALL have parameter DWIDTH, default 16: divisor and remainder width in bits.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 i_clk  input  1  rising-edge clock for all state.
REQ-005 i_reset  input  1  synchronous active-high reset.
REQ-006 i_start  input  1  request a divide; sampled only in IDLE.
REQ-007 i_n  input  NWIDTH  unsigned dividend; captured with the accepted i_start.
REQ-008 i_d  input  DWIDTH  unsigned divisor; captured with the accepted i_start.
REQ-009 o_busy  output  1  high while a division is in progress.
REQ-010 o_valid  output  1  single-cycle pulse; results are valid.
REQ-011 o_quot  output  NWIDTH  quotient, floor(n/d).
REQ-012 o_rem  output  DWIDTH  remainder, n mod d.
REQ-013 o_div_by_zero  output  1  high when the captured divisor was zero; valid with o_valid.

Function
REQ-014 SHALL implement the FSM states IDLE, CALC and DONE; reset state is IDLE.
REQ-015 In IDLE, i_start=1 at clock edge k SHALL capture i_n and i_d, then:
- d != 0: go to CALC.
- d == 0: go to DONE.
REQ-016 With i_start=0 in IDLE, the block SHALL stay in IDLE; o_quot, o_rem and o_div_by_zero SHALL hold their last values.
REQ-017 CALC SHALL run restoring division, MSB first, one quotient bit per cycle, for exactly NWIDTH cycles using an internal bit counter.
REQ-018 Each CALC step SHALL work on a partial remainder r, which SHALL be DWIDTH+1 bits so that no overflow occurs:
- r' = {r, next dividend bit}.
- If r' >= d: r = r' - d and the quotient bit is 1.
- Otherwise: r = r' and the quotient bit is 0.
REQ-019 After the last CALC step, the block SHALL go to DONE; DONE SHALL last one cycle and then return to IDLE.
REQ-020 o_busy SHALL be 1 in CALC and 0 in IDLE and DONE.
- Nonzero divisor: o_busy is high for cycles k+1 .. k+NWIDTH.
- Zero divisor: o_busy is never high.
REQ-021 o_valid SHALL be 1 only in DONE.
- Nonzero divisor: o_valid is high at cycle k+NWIDTH+1 (17 cycles after acceptance for the default widths).
- Zero divisor: o_valid is high at cycle k+1.
REQ-022 o_quot and o_rem SHALL be registered and SHALL update only on entry to DONE.
REQ-023 o_div_by_zero SHALL also update only on entry to DONE.
REQ-024 For any n and any d != 0, results SHALL satisfy o_quot*d + o_rem == n and o_rem < d; o_div_by_zero SHALL be 0.
REQ-025 For d == 0: o_quot SHALL be all ones, o_rem SHALL be 0, and o_div_by_zero SHALL be 1.
REQ-026 i_start SHALL be ignored while in CALC or DONE; a request during DONE SHALL NOT be queued.
REQ-027 A new i_start in the first IDLE cycle after DONE SHALL be accepted.
REQ-028 Changes on i_n and i_d after capture SHALL NOT affect the result in progress.
REQ-029 The boundary n=0 SHALL produce o_quot=0 and o_rem=0.
REQ-030 The boundary n=2^NWIDTH-1, d=1 SHALL produce o_quot=2^NWIDTH-1 and o_rem=0.
REQ-031 n < d SHALL produce o_quot=0 and o_rem=n.

Reset
REQ-032 When i_reset=1 at a clock edge, the next state SHALL be IDLE.
REQ-033 The same reset SHALL force o_busy=0, o_valid=0, o_quot=0, o_rem=0, o_div_by_zero=0, the bit counter to 0 and the partial remainder to 0.
REQ-034 Reset SHALL take priority over i_start.
REQ-035 Reset asserted mid-CALC SHALL abort the division with no o_valid pulse.
REQ-036 The first i_start after reset deasserts SHALL be accepted normally.

Verification
REQ-037 The bench SHALL cover the following directed scenarios (default widths, start accepted at edge k):
- i_n=100, i_d=7 -> o_busy high k+1..k+16; o_valid at k+17 with o_quot=14, o_rem=2, o_div_by_zero=0.
- i_n=50, i_d=5 -> o_quot=10, o_rem=0 at k+17; i_n=3, i_d=9 -> o_quot=0, o_rem=3.
- i_n=0xFFFF, i_d=1 -> o_quot=0xFFFF, o_rem=0; i_n=0xFFFF, i_d=0xFFFF -> o_quot=1, o_rem=0.
- i_n=5, i_d=0 -> o_valid at k+1 with o_quot=0xFFFF, o_rem=0, o_div_by_zero=1; o_busy never high.
- i_n=100, i_d=7 accepted, then i_start with i_n=9, i_d=3 at k+5 -> ignored; o_quot=14, o_rem=2 at k+17; start at k+18 -> o_quot=3, o_rem=0 at k+35.
- i_reset=1 at k+8 of a division -> no o_valid; all outputs 0 one cycle later; a following 100/7 completes correctly.
REQ-038 The bench SHALL additionally run at least 1000 random (n, d) pairs and check REQ-024, or REQ-025 when d == 0, on every o_valid pulse.

Source files
------------

// File: rtl/unsigned_divide.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// Divide-by-zero finishes in one cycle with an all-ones quotient and the flag set.
module unsigned_divide #(
  parameter int unsigned NWIDTH = 16,
  parameter int unsigned DWIDTH = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [NWIDTH-1:0] i_n,
  input  logic [DWIDTH-1:0] i_d,
  output logic              o_busy,
  output logic              o_valid,
  output logic [NWIDTH-1:0] o_quot,
  output logic [DWIDTH-1:0] o_rem,
  output logic              o_div_by_zero
);

  localparam int unsigned CW = $clog2(NWIDTH + 1);
  localparam int unsigned PW = DWIDTH + 1;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            r_state;
  logic [NWIDTH-1:0] r_n;
  logic [DWIDTH-1:0] r_d;
  logic [PW-1:0]     r_part;
  logic [CW-1:0]     r_cnt;
  logic              r_busy;
  logic              r_valid;
  logic [NWIDTH-1:0] r_quot;
  logic [DWIDTH-1:0] r_rem;
  logic              r_dbz;

  logic [PW:0]       w_shift;
  logic [PW:0]       w_dext;
  logic              w_ge;
  logic [PW-1:0]     w_part_next;
  logic [NWIDTH-1:0] w_n_next;
  logic              w_last;

  // r_n holds the unconsumed dividend bits at the top and collects quotient bits at the bottom.
  always_comb begin
    w_shift     = {r_part, r_n[NWIDTH-1]};
    w_dext      = {2'b00, r_d};
    w_ge        = (w_shift >= w_dext);
    w_part_next = w_ge ? PW'(w_shift - w_dext) : PW'(w_shift);
    w_n_next    = {r_n[NWIDTH-2:0], w_ge};
    w_last      = (r_cnt == CW'(NWIDTH - 1));
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_n     <= '0;
      r_d     <= '0;
      r_part  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_valid <= 1'b0;
          if (i_start) begin
            r_n    <= i_n;
            r_d    <= i_d;
            r_part <= '0;
            r_cnt  <= '0;
            if (i_d == '0) begin
              r_state <= StDone;
              r_valid <= 1'b1;
              r_quot  <= '1;
              r_rem   <= '0;
              r_dbz   <= 1'b1;
            end else begin
              r_state <= StCalc;
              r_busy  <= 1'b1;
            end
          end
        end
        StCalc: begin
          r_n    <= w_n_next;
          r_part <= w_part_next;
          r_cnt  <= r_cnt + CW'(1);
          if (w_last) begin
            r_state <= StDone;
            r_busy  <= 1'b0;
            r_valid <= 1'b1;
            r_quot  <= w_n_next;
            r_rem   <= DWIDTH'(w_part_next);
            r_dbz   <= 1'b0;
          end
        end
        StDone: begin
          r_valid <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_valid       = r_valid;
  assign o_quot        = r_quot;
  assign o_rem         = r_rem;
  assign o_div_by_zero = r_dbz;

endmodule
